pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 3-stage core (IF, ID, EX). It drives the stall_n and flush controls of the PC, IF/ID and ID/EX pipeline registers. It resolves load-use hazards, bus wait states, taken branches, trap entry and WFI sleep with one fixed priority. The ID/EX register clears itself on exception_id && stall_n, so this block holds stall_n low while sleeping to protect an in-flight WFI.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 34 +++
 rtl/pipeline_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types for the pipeline stall/flush sequencer:
//               controller state encoding, register-zero index and the
//               bundle of stall/flush control bits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_FLUSH = 2'd1,
        WFI_SLEEP  = 2'd2
    } pipe_state_e;

    // x0 is hard-wired to zero, so a write to it never creates a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Stall (active-low enables) and flush controls for the pipeline registers
    typedef struct packed {
        logic pc_stall_n;
        logic if_id_stall_n;
        logic id_ex_stall_n;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_out_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
//==============================================================================
// Module      : hazard_detect
// Description : Purely combinational load-use comparator. Flags when the ID
//               instruction reads a register that the load in EX is about
//               to write.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_load_i,
    input  logic       ex_reg_wen_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_rs1_ren_i,
    input  logic       id_rs2_ren_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       load_use_o
);

    logic ld_writes_reg;
    logic rs1_hit;
    logic rs2_hit;

    assign ld_writes_reg = ex_load_i && ex_reg_wen_i && (ex_rd_addr_i != REG_ZERO);
    assign rs1_hit       = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit       = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign load_use_o    = ld_writes_reg && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
//==============================================================================
// Module      : pipeline_ctrl
// Description : Central stall/flush sequencer for the 3-stage core (IF, ID,
//               EX). Resolves bus wait states, trap entry, taken branches,
//               load-use hazards and WFI sleep with one fixed priority.
//               Control outputs are combinational from state and inputs.
//               Optional performance counters are built when the macro
//               PIPE_CTRL_PERF_CNT_EN is defined; otherwise the counter
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2,
    parameter int unsigned STALL_CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_sync,
    input  logic                   id_rs1_ren,
    input  logic                   id_rs2_ren,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic                   ex_load,
    input  logic                   ex_reg_wen,
    input  logic [4:0]             ex_rd_addr,
    input  logic                   mem_busy,
    input  logic                   branch_taken_ex,
    input  logic                   trap_req,
    input  logic                   wfi_id,
    input  logic                   irq_pending,
    output logic                   pc_stall_n,
    output logic                   if_id_stall_n,
    output logic                   id_ex_stall_n,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   sleeping,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] flush_events
);

    // Remaining TRAP_FLUSH cycles after the entry cycle itself
    localparam logic [3:0] TRAP_CNT_INIT  = 4'(TRAP_FLUSH_CYCLES - 1);
    // A one-cycle trap flush is fully covered by the entry cycle
    localparam logic       TRAP_NEEDS_ST  = (TRAP_FLUSH_CYCLES > 1);

    localparam ctrl_out_t CTRL_RUN    = '{pc_stall_n: 1'b1, if_id_stall_n: 1'b1,
                                          id_ex_stall_n: 1'b1, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b0};
    localparam ctrl_out_t CTRL_FLUSH  = '{pc_stall_n: 1'b1, if_id_stall_n: 1'b1,
                                          id_ex_stall_n: 1'b1, if_id_flush: 1'b1,
                                          id_ex_flush: 1'b1};
    localparam ctrl_out_t CTRL_FREEZE = '{pc_stall_n: 1'b0, if_id_stall_n: 1'b0,
                                          id_ex_stall_n: 1'b0, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b0};
    localparam ctrl_out_t CTRL_BUBBLE = '{pc_stall_n: 1'b0, if_id_stall_n: 1'b0,
                                          id_ex_stall_n: 1'b1, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b1};

    pipe_state_e state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    ctrl_out_t   ctrl;
    logic        sleep_out;
    logic        load_use;
    logic        any_stall;
    logic        any_flush;

    hazard_detect u_hazard_detect (
        .ex_load_i     (ex_load),
        .ex_reg_wen_i  (ex_reg_wen),
        .ex_rd_addr_i  (ex_rd_addr),
        .id_rs1_ren_i  (id_rs1_ren),
        .id_rs2_ren_i  (id_rs2_ren),
        .id_rs1_addr_i (id_rs1_addr),
        .id_rs2_addr_i (id_rs2_addr),
        .load_use_o    (load_use)
    );

    // State and trap-flush counter registers
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and control-output decode, fixed priority inside RUN
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ctrl        = CTRL_RUN;
        sleep_out   = 1'b0;

        if (rst_sync) begin
            ctrl        = CTRL_FLUSH;
            state_d     = RUN;
            flush_cnt_d = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        // Bus access is never abandoned; a trap waits behind it
                        ctrl = CTRL_FREEZE;
                    end else if (trap_req) begin
                        ctrl = CTRL_FLUSH;
                        if (TRAP_NEEDS_ST) begin
                            state_d     = TRAP_FLUSH;
                            flush_cnt_d = TRAP_CNT_INIT;
                        end
                    end else if (branch_taken_ex) begin
                        // The ID instruction is discarded, so a hazard is moot
                        ctrl = CTRL_FLUSH;
                    end else if (load_use) begin
                        ctrl = CTRL_BUBBLE;
                    end else if (wfi_id) begin
                        state_d = WFI_SLEEP;
                    end
                end

                TRAP_FLUSH: begin
                    ctrl = CTRL_FLUSH;
                    if (flush_cnt_q <= 4'd1) begin
                        flush_cnt_d = 4'd0;
                        state_d     = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end

                WFI_SLEEP: begin
                    if (trap_req) begin
                        ctrl = CTRL_FLUSH;
                        if (TRAP_NEEDS_ST) begin
                            state_d     = TRAP_FLUSH;
                            flush_cnt_d = TRAP_CNT_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (irq_pending) begin
                        // Wake cycle: pipe stays frozen, sleeping already low
                        ctrl    = CTRL_FREEZE;
                        state_d = RUN;
                    end else begin
                        // Hold stall_n low so the in-flight WFI is not cleared
                        ctrl      = CTRL_FREEZE;
                        sleep_out = 1'b1;
                    end
                end

                default: begin
                    state_d     = RUN;
                    flush_cnt_d = 4'd0;
                end
            endcase
        end
    end

    assign pc_stall_n    = ctrl.pc_stall_n;
    assign if_id_stall_n = ctrl.if_id_stall_n;
    assign id_ex_stall_n = ctrl.id_ex_stall_n;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign sleeping      = sleep_out;

    assign any_stall = !(ctrl.pc_stall_n && ctrl.if_id_stall_n && ctrl.id_ex_stall_n);
    assign any_flush = ctrl.if_id_flush || ctrl.id_ex_flush;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STALL_CNT_W-1:0] flush_evt_q, flush_evt_d;
    logic                   flush_prev_q;

    // Counter increments; reset cycles never count
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_evt_d = flush_evt_q;
        if (any_stall) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
        if (any_flush && !flush_prev_q) begin
            flush_evt_d = flush_evt_q + STALL_CNT_W'(1);
        end
    end

    // Performance counter registers, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            stall_cnt_q  <= '0;
            flush_evt_q  <= '0;
            flush_prev_q <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_evt_q  <= flush_evt_d;
            flush_prev_q <= any_flush;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_evt_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
//==============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the sequencer. Counter expectations
//               follow PIPE_CTRL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    localparam int TFC = 2;
    localparam int W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_sync, id_rs1_ren, id_rs2_ren, ex_load, ex_reg_wen;
    logic [4:0]   id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic         mem_busy, branch_taken_ex, trap_req, wfi_id, irq_pending;
    logic         pc_stall_n, if_id_stall_n, id_ex_stall_n;
    logic         if_id_flush, id_ex_flush, sleeping;
    logic [W-1:0] stall_cycles, flush_events;

    pipeline_ctrl #(.TRAP_FLUSH_CYCLES(TFC), .STALL_CNT_W(W)) dut (
        .clk             (clk),
        .rst_sync        (rst_sync),
        .id_rs1_ren      (id_rs1_ren),
        .id_rs2_ren      (id_rs2_ren),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .ex_load         (ex_load),
        .ex_reg_wen      (ex_reg_wen),
        .ex_rd_addr      (ex_rd_addr),
        .mem_busy        (mem_busy),
        .branch_taken_ex (branch_taken_ex),
        .trap_req        (trap_req),
        .wfi_id          (wfi_id),
        .irq_pending     (irq_pending),
        .pc_stall_n      (pc_stall_n),
        .if_id_stall_n   (if_id_stall_n),
        .id_ex_stall_n   (id_ex_stall_n),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .sleeping        (sleeping),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: trap flush cycles still owed, sleep flag, counters
    int           trap_left  = 0;
    bit           asleep     = 1'b0;
    bit           flush_prev = 1'b0;
    logic [W-1:0] m_stall    = '0;
    logic [W-1:0] m_flush    = '0;

    task automatic clr_in();
        rst_sync = 0; id_rs1_ren = 0; id_rs2_ren = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        ex_load = 0; ex_reg_wen = 0; ex_rd_addr = 0; mem_busy = 0;
        branch_taken_ex = 0; trap_req = 0; wfi_id = 0; irq_pending = 0;
    endtask

    // Check this cycle's combinational outputs, advance one clock, check counters.
    // Expected vector order: {pc, if_id, id_ex stall_n, if_id flush, id_ex flush, sleeping}
    task automatic tick(input string tag);
        logic [5:0] e;
        bit hz, f;
        #2;
        hz = ex_load && ex_reg_wen && (ex_rd_addr != 0) &&
             ((id_rs1_ren && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_ren && id_rs2_addr == ex_rd_addr));
        e = 6'b111000;
        if (rst_sync) begin
            e = 6'b111110; trap_left = 0; asleep = 0;
        end else if (trap_left > 0) begin
            e = 6'b111110; trap_left--;
        end else if (asleep) begin
            if (trap_req) begin
                e = 6'b111110; asleep = 0; trap_left = TFC - 1;
            end else if (irq_pending) begin
                e = 6'b000000; asleep = 0;
            end else begin
                e = 6'b000001;
            end
        end else if (mem_busy) begin
            e = 6'b000000;
        end else if (trap_req) begin
            e = 6'b111110; trap_left = TFC - 1;
        end else if (branch_taken_ex) begin
            e = 6'b111110;
        end else if (hz) begin
            e = 6'b001010;
        end else if (wfi_id) begin
            asleep = 1;
        end
        check_eq({tag, " ctrl"}, 64'({pc_stall_n, if_id_stall_n, id_ex_stall_n,
                                      if_id_flush, id_ex_flush, sleeping}), 64'(e));
        f = e[2] | e[1];
        if (rst_sync) begin
            m_stall = '0; m_flush = '0; flush_prev = 0;
        end else begin
            if (e[5:3] != 3'b111) m_stall = m_stall + 1'b1;
            if (f && !flush_prev) m_flush = m_flush + 1'b1;
            flush_prev = f;
        end
        @(posedge clk);
        #1;
`ifdef PIPE_CTRL_PERF_CNT_EN
        check_eq({tag, " stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
        check_eq({tag, " flush_events"}, 64'(flush_events), 64'(m_flush));
`else
        check_eq({tag, " stall_cycles"}, 64'(stall_cycles), 64'd0);
        check_eq({tag, " flush_events"}, 64'(flush_events), 64'd0);
`endif
    endtask

    initial begin
        clr_in();
        rst_sync = 1;
        tick("reset0");
        tick("reset1");
        clr_in();
        tick("reset_state");

        // Load-use hazard on rs2, then bus freeze with a waiting trap
        ex_load = 1; ex_reg_wen = 1; ex_rd_addr = 5; id_rs2_ren = 1; id_rs2_addr = 5;
        tick("hazard");
        clr_in();
        mem_busy = 1; trap_req = 1;
        for (int i = 0; i < 3; i++) tick("bus_freeze");
`ifdef PIPE_CTRL_PERF_CNT_EN
        check_eq("perf stall_cycles", 64'(stall_cycles), 64'd4);
        check_eq("perf flush_events", 64'(flush_events), 64'd1);
`endif
        mem_busy = 0;
        tick("trap_entry");
        tick("trap_flush");
        trap_req = 0;
        tick("after_trap");

        // rd = x0 never stalls
        ex_load = 1; ex_reg_wen = 1; ex_rd_addr = 0; id_rs2_ren = 1; id_rs2_addr = 0;
        tick("hazard_rd0");
        // Branch overrides hazard
        ex_rd_addr = 7; id_rs1_ren = 1; id_rs1_addr = 7; branch_taken_ex = 1;
        tick("branch_over_hazard");
        clr_in();

        // WFI sleep and interrupt wake
        wfi_id = 1;
        tick("wfi_enter");
        wfi_id = 0;
        tick("sleep0");
        tick("sleep1");
        irq_pending = 1;
        tick("wake");
        irq_pending = 0;
        tick("after_wake");

        // WFI sleep interrupted by trap
        wfi_id = 1;
        tick("wfi_enter2");
        wfi_id = 0; trap_req = 1;
        tick("sleep_trap");
        tick("sleep_trap_flush");
        trap_req = 0;

        // Reset in the middle of TRAP_FLUSH
        trap_req = 1;
        tick("trap_before_rst");
        rst_sync = 1;
        tick("rst_mid_flush");
        clr_in();
        tick("after_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_sync        = ($urandom_range(0, 99) < 2);
            mem_busy        = ($urandom_range(0, 99) < 15);
            trap_req        = ($urandom_range(0, 99) < 6);
            branch_taken_ex = ($urandom_range(0, 99) < 12);
            wfi_id          = ($urandom_range(0, 99) < 15);
            irq_pending     = ($urandom_range(0, 99) < 25);
            ex_load         = $urandom_range(0, 1);
            ex_reg_wen      = $urandom_range(0, 1);
            ex_rd_addr      = 5'($urandom_range(0, 3));
            id_rs1_ren      = $urandom_range(0, 1);
            id_rs2_ren      = $urandom_range(0, 1);
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
